// File: rtl/raster_line_scanner.sv
// raster_line_scanner: double-buffered line store drained to a laser intensity output,
// paced by pixel_tick and started by facet_sync. Define SCAN_BIDIR_EN for serpentine scanning.
module raster_line_scanner #(
  parameter int LINE_PIXELS = 320,
  parameter int START_DELAY = 16,
  parameter int DATA_W      = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_sop,
  input  logic              s_eop,
  output logic              s_ready,
  input  logic              pixel_tick,
  input  logic              facet_sync,
  input  logic              clr_flags,
  output logic [DATA_W-1:0] laser_pwr,
  output logic              laser_en,
  output logic              line_done,
  output logic              underflow,
  output logic              sync_err
);
  localparam int AW  = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;
  localparam int DLW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam logic [AW-1:0]  LAST_ADDR  = AW'(LINE_PIXELS - 1);
  localparam logic [DLW-1:0] LAST_DLY   = DLW'((START_DELAY > 0) ? START_DELAY - 1 : 0);
  localparam logic [AW:0]    LINE_OFF   = (AW + 1)'(LINE_PIXELS);
  localparam bit             ZERO_DELAY = (START_DELAY == 0);

  typedef enum logic [1:0] {IDLE, DELAY, SCAN} state_t;
  state_t state_reg, state_next;

  logic              p_reg, wb_reg, rb_reg;
  logic [AW-1:0]     wr_addr_reg, pix_cnt_reg, wr_ptr, rd_ptr;
  logic [DLW-1:0]    dly_cnt_reg;
  logic [AW:0]       wr_index, rd_index;
  logic [DATA_W-1:0] rd_data_reg;
  logic [DATA_W-1:0] line_mem [0:2*LINE_PIXELS-1];
  logic              tick_d1_reg, last_d1_reg, tail_reg;
  logic              accept, line_complete, blank;
  logic              swap, uf_set, se_set, scan_rd, scan_last, enter_scan;

  assign s_ready       = !p_reg;
  assign accept        = s_valid && !p_reg;
  assign wr_ptr        = s_sop ? '0 : wr_addr_reg;
  assign line_complete = accept && (s_eop || wr_ptr == LAST_ADDR);
  // The last pixel stays lit until the next pixel_tick, then the laser goes dark.
  assign blank         = pixel_tick && tail_reg;
  assign wr_index      = {1'b0, wr_ptr} + (wb_reg ? LINE_OFF : '0);
  assign rd_index      = {1'b0, rd_ptr} + (rb_reg ? LINE_OFF : '0);

`ifdef SCAN_BIDIR_EN
  logic parity_reg;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         parity_reg <= 1'b0;
    else if (last_d1_reg) parity_reg <= ~parity_reg;
  end
  assign rd_ptr = parity_reg ? (LAST_ADDR - pix_cnt_reg) : pix_cnt_reg;
`else
  assign rd_ptr = pix_cnt_reg;
`endif

  // Buffer storage is never reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (accept)  line_mem[wr_index] <= s_data;
    if (scan_rd) rd_data_reg <= line_mem[rd_index];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    swap       = 1'b0;
    uf_set     = 1'b0;
    se_set     = 1'b0;
    scan_rd    = 1'b0;
    scan_last  = 1'b0;
    enter_scan = 1'b0;
    case (state_reg)
      IDLE: begin
        if (facet_sync) begin
          if (p_reg) begin
            swap       = 1'b1;
            state_next = DELAY;
          end else begin
            uf_set = 1'b1;
          end
        end
      end
      DELAY: begin
        se_set = facet_sync;
        if (ZERO_DELAY || (pixel_tick && dly_cnt_reg == LAST_DLY)) begin
          enter_scan = 1'b1;
          state_next = SCAN;
        end
      end
      SCAN: begin
        se_set = facet_sync;
        if (pixel_tick) begin
          scan_rd = 1'b1;
          if (pix_cnt_reg == LAST_ADDR) begin
            scan_last  = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_reg       <= 1'b0;
      wb_reg      <= 1'b0;
      rb_reg      <= 1'b1;
      wr_addr_reg <= '0;
      pix_cnt_reg <= '0;
      dly_cnt_reg <= '0;
      tick_d1_reg <= 1'b0;
      last_d1_reg <= 1'b0;
      tail_reg    <= 1'b0;
      laser_pwr   <= '0;
      laser_en    <= 1'b0;
      line_done   <= 1'b0;
      underflow   <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      // A swap needs P=1 and a completion needs P=0, so they never coincide.
      if (swap) begin
        rb_reg <= wb_reg;
        wb_reg <= ~wb_reg;
        p_reg  <= 1'b0;
      end else if (line_complete) begin
        p_reg <= 1'b1;
      end
      if (accept) wr_addr_reg <= line_complete ? '0 : wr_ptr + 1'b1;

      if (swap)                                dly_cnt_reg <= '0;
      else if (state_reg == DELAY && pixel_tick) dly_cnt_reg <= dly_cnt_reg + 1'b1;

      if (enter_scan)   pix_cnt_reg <= '0;
      else if (scan_rd) pix_cnt_reg <= scan_last ? '0 : pix_cnt_reg + 1'b1;

      tick_d1_reg <= scan_rd;
      last_d1_reg <= scan_last;
      line_done   <= last_d1_reg;

      if (tick_d1_reg) laser_pwr <= rd_data_reg;
      else if (blank)  laser_pwr <= '0;

      if (enter_scan) laser_en <= 1'b1;
      else if (blank) laser_en <= 1'b0;

      if (last_d1_reg)                   tail_reg <= 1'b1;
      else if (enter_scan || pixel_tick) tail_reg <= 1'b0;

      if (uf_set)         underflow <= 1'b1;
      else if (clr_flags) underflow <= 1'b0;
      if (se_set)         sync_err <= 1'b1;
      else if (clr_flags) sync_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_raster_line_scanner.sv
// Randomized bench for raster_line_scanner with a line/event-level reference model.
// Build with SCAN_BIDIR_EN defined to check alternating scan direction.
module tb_raster_line_scanner;
  localparam int LP = 8;
  localparam int SD = 2;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [DW-1:0] s_data;
  logic          s_valid, s_sop, s_eop, s_ready;
  logic          pixel_tick, facet_sync, clr_flags;
  logic [DW-1:0] laser_pwr;
  logic          laser_en, line_done, underflow, sync_err;

  always #5 clk = ~clk;

  raster_line_scanner #(.LINE_PIXELS(LP), .START_DELAY(SD), .DATA_W(DW)) dut (
    .clk(clk), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid), .s_sop(s_sop),
    .s_eop(s_eop), .s_ready(s_ready), .pixel_tick(pixel_tick), .facet_sync(facet_sync),
    .clr_flags(clr_flags), .laser_pwr(laser_pwr), .laser_en(laser_en),
    .line_done(line_done), .underflow(underflow), .sync_err(sync_err)
  );

  typedef struct { logic [7:0] d; bit sop; bit eop; } beat_t;
  typedef struct { int due; int val; bit last; } ev_t;

  beat_t beat_q[$];
  ev_t   ev_q[$];
  int    m_buf [2][LP];
  int    m_wb, m_rb, m_p, m_waddr, m_state, m_dcnt, m_pcnt, m_parity, m_tail, m_uf, m_se;
  int    e_pwr, e_en, e_done;
  int    cyc, done_seen, done_exp;
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_wb = 0; m_rb = 1; m_p = 0; m_waddr = 0; m_state = 0; m_dcnt = 0; m_pcnt = 0;
    m_parity = 0; m_tail = 0; m_uf = 0; m_se = 0;
    e_pwr = 0; e_en = 0; e_done = 0;
    ev_q.delete();
    beat_q.delete();
  endtask

  task automatic check_outputs();
    check("laser_pwr", laser_pwr, e_pwr);
    check("laser_en", laser_en, e_en);
    check("line_done", line_done, e_done);
    check("underflow", underflow, m_uf);
    check("sync_err", sync_err, m_se);
    check("s_ready", s_ready, (m_p != 0) ? 0 : 1);
    if (line_done === 1'b1) done_seen++;
  endtask

  task automatic push_beat(input logic [7:0] d, input bit sop, input bit eop);
    beat_t b;
    b.d = d; b.sop = sop; b.eop = eop;
    beat_q.push_back(b);
  endtask

  // One clock: check what the previous edge produced, drive inputs, predict the next edge.
  task automatic step(input bit fs, input bit clr, input int tick_pct);
    bit    tk, v, uf_s, se_s;
    int    p_old, wb_old, wa, a;
    beat_t b;
    ev_t   e;
    @(negedge clk);
    check_outputs();
    tk = ($urandom_range(99) < tick_pct);
    v  = (beat_q.size() > 0);
    if (v) b = beat_q[0];
    else begin b.d = 8'd0; b.sop = 1'b0; b.eop = 1'b0; end
    s_valid = v; s_data = b.d; s_sop = b.sop; s_eop = b.eop;
    pixel_tick = tk; facet_sync = fs; clr_flags = clr;

    cyc++;
    p_old = m_p; wb_old = m_wb; uf_s = 0; se_s = 0; e_done = 0;
    if (tk && m_tail != 0) begin e_pwr = 0; e_en = 0; m_tail = 0; end
    while (ev_q.size() > 0 && ev_q[0].due == cyc) begin
      e_pwr = ev_q[0].val;
      if (ev_q[0].last) begin e_done = 1; m_tail = 1; m_parity ^= 1; done_exp++; end
      void'(ev_q.pop_front());
    end
    case (m_state)
      0: if (fs) begin
           if (p_old != 0) begin
             m_rb = wb_old; m_wb = 1 - wb_old; m_p = 0; m_state = 1; m_dcnt = 0;
           end else uf_s = 1;
         end
      1: begin
           if (fs) se_s = 1;
           if (tk) begin
             m_dcnt++;
             if (m_dcnt == SD) begin m_state = 2; m_pcnt = 0; e_en = 1; m_tail = 0; end
           end
         end
      default: begin
           if (fs) se_s = 1;
           if (tk) begin
`ifdef SCAN_BIDIR_EN
             a = (m_parity != 0) ? LP - 1 - m_pcnt : m_pcnt;
`else
             a = m_pcnt;
`endif
             e.due = cyc + 1; e.val = m_buf[m_rb][a]; e.last = (m_pcnt == LP - 1);
             ev_q.push_back(e);
             m_pcnt++;
             if (m_pcnt == LP) m_state = 0;
           end
         end
    endcase
    if (v && p_old == 0) begin
      wa = b.sop ? 0 : m_waddr;
      m_buf[wb_old][wa] = b.d;
      if (b.eop || wa == LP - 1) begin m_p = 1; m_waddr = 0; end
      else m_waddr = wa + 1;
      void'(beat_q.pop_front());
    end
    if (uf_s) m_uf = 1; else if (clr) m_uf = 0;
    if (se_s) m_se = 1; else if (clr) m_se = 0;
  endtask

  task automatic run(input int n, input int pct);
    for (int i = 0; i < n; i++) step(0, 0, pct);
  endtask

  task automatic wait_p(input string tag, input int pct);
    int n = 0;
    while (m_p == 0 && n < 100) begin step(0, 0, pct); n++; end
    if (m_p == 0) check({tag, "_timeout"}, n, 0);
  endtask

  task automatic wait_scan(input string tag, input int pct);
    int n = 0;
    while ((m_state != 0 || ev_q.size() != 0 || m_tail != 0) && n < 400) begin
      step(0, 0, pct); n++;
    end
    if (n == 400) check({tag, "_timeout"}, n, 0);
  endtask

  task automatic push_rand_line(input int n, input bit sop);
    for (int i = 0; i < n; i++)
      push_beat(8'($urandom_range(255)), sop && (i == 0), (i == n - 1) && (n < LP));
  endtask

  task automatic do_reset(input bit mid);
    #2;
    s_valid = 0; s_sop = 0; s_eop = 0; pixel_tick = 0; facet_sync = 0; clr_flags = 0;
    reset_n = 1'b0;
    #1;
    if (mid) begin
      check("rst_laser_pwr", laser_pwr, 0);
      check("rst_laser_en", laser_en, 0);
    end
    @(posedge clk); @(posedge clk); #2;
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int d0, n;
    cyc = 0; done_seen = 0; done_exp = 0;
    foreach (m_buf[i, j]) m_buf[i][j] = 0;
    s_data = 0; s_valid = 0; s_sop = 0; s_eop = 0;
    pixel_tick = 0; facet_sync = 0; clr_flags = 0;
    reset_n = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #2;
    reset_n = 1'b1;
    run(2, 0);

    // Underflow on an empty buffer, then clear.
    step(1, 0, 100); step(0, 0, 100);
    check("uf_set", underflow, 1);
    check("uf_dark", laser_en, 0);
    run(4, 100);
    step(0, 1, 0); step(0, 0, 0);
    check("uf_clr", underflow, 0);

    // Full line 1..8, continuous ticks.
    for (int i = 1; i <= LP; i++) push_beat(8'(i), i == 1, 1'b0);
    wait_p("l1_load", 0);
    d0 = done_seen;
    step(1, 0, 100);
    wait_scan("l1_scan", 100);
    run(2, 100);
    check("l1_done_cnt", done_seen - d0, 1);

    // Line A scanning while B completes and C is held off.
    push_rand_line(LP, 1);
    wait_p("la_load", 50);
    step(1, 0, 50);
    push_rand_line(LP, 1);
    push_rand_line(LP, 1);
    wait_scan("la_scan", 50);
    step(0, 0, 50);
    check("c_held", s_ready, 0);
    step(1, 0, 50);
    wait_p("lc_load", 50);
    step(1, 0, 50);
    wait_scan("lb_scan", 60);
    step(1, 0, 60);
    wait_scan("lc_scan", 60);

    // Short line with stale tail.
    push_beat(8'd5, 1, 0); push_beat(8'd6, 0, 0); push_beat(8'd7, 0, 1);
    wait_p("short_load", 0);
    step(0, 0, 0);
    check("short_p", s_ready, 0);
    step(1, 0, 100);
    wait_scan("short_scan", 100);

    // Completion and facet_sync in the same cycle.
    push_rand_line(LP, 1);
    while (beat_q.size() > 1) step(0, 0, 0);
    step(1, 0, 0); step(0, 0, 0);
    check("same_uf", underflow, 1);
    check("same_p", s_ready, 0);
    step(0, 1, 0);

    // facet_sync mid-scan, then reset mid-scan.
    step(1, 0, 100);
    n = 0;
    while (!(m_state == 2 && m_pcnt == 3) && n < 50) begin step(0, 0, 100); n++; end
    if (n == 50) check("mid_timeout", n, 0);
    step(1, 0, 100); step(0, 0, 100);
    check("se_set", sync_err, 1);
    run(3, 100);
    do_reset(1);

    // Randomized traffic.
    for (int k = 0; k < 1500; k++) begin
      if (beat_q.size() == 0 && $urandom_range(3) == 0)
        push_rand_line($urandom_range(1, LP), $urandom_range(9) != 0);
      step($urandom_range(99) < 3, $urandom_range(99) < 2, 60);
    end
    wait_scan("rand_tail", 60);
    run(2, 60);
    check("done_total", done_seen, done_exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
